reg_write_arbiter: RTL and testbench

//  Shares one WIDTH-bit load-enable register among N_REQ requesters.

---
 rtl/reg_write_arbiter_if.sv | 24 ++
 rtl/reg_write_arbiter.sv | 99 +++++++++
 tb/tb_reg_write_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_write_arbiter_if.sv
// Requester-side bus of the shared-register write arbiter: requests and data in,
// grant and register drive signals out.
interface reg_write_arbiter_if #(
   parameter int WIDTH = 8,
   parameter int N_REQ = 4
) ();
   logic [N_REQ-1:0]       req;
   logic [N_REQ*WIDTH-1:0] req_data;
   logic [N_REQ-1:0]       gnt;
   logic                   load;
   logic [WIDTH-1:0]       data_in;
   logic [2:0]             owner;
   logic                   busy;

   modport master (
      output req, req_data,
      input  gnt, load, data_in, owner, busy
   );

   modport slave (
      input  req, req_data,
      output gnt, load, data_in, owner, busy
   );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one load-enable register among N_REQ requesters,
// with bounded burst ownership and a release bubble between owners.
module reg_write_arbiter #(
   parameter int WIDTH     = 8,
   parameter int N_REQ     = 4,
   parameter int MAX_BURST = 4
) (
   input logic          clk,
   input logic          rst,
   reg_write_arbiter_if.slave bus
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state;
   logic [2:0] ptr;
   logic [2:0] owner_q;
   logic [3:0] burst_cnt;
   logic       bubble;

   logic [2:0] winner;
   logic       found;
   logic       grant_now;
   logic [2:0] next_ptr;

   function automatic logic [2:0] wrap_add(input logic [2:0] base, input int k);
      int s;
      s = int'(base) + k;
      return (s >= N_REQ) ? 3'(s - N_REQ) : 3'(s);
   endfunction

   // Round-robin search starting at ptr.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      winner = '0;
      found  = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found && bus.req[wrap_add(ptr, k)]) begin
            winner = wrap_add(ptr, k);
            found  = 1'b1;
         end
      end
   end

   assign next_ptr  = (owner_q == 3'(N_REQ - 1)) ? 3'd0 : owner_q + 3'd1;
   assign grant_now = (state == GRANT) && bus.req[owner_q];

   always_comb begin
      bus.gnt     = '0;
      bus.data_in = '0;
      if (grant_now) begin
         bus.gnt[owner_q] = 1'b1;
         bus.data_in      = bus.req_data[owner_q*WIDTH +: WIDTH];
      end
   end

   assign bus.load  = grant_now;
   assign bus.owner = owner_q;
   assign bus.busy  = (state == GRANT);

   // The first IDLE cycle after an ownership is a bubble; arbitration happens on the next one.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: all sequential state uses nonblocking assignments so every register samples pre-edge values.
      if (!rst) begin
         state     <= IDLE;
         ptr       <= '0;
         owner_q   <= '0;
         burst_cnt <= '0;
         bubble    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bubble) begin
                  bubble <= 1'b0;
               end else if (found) begin
                  owner_q   <= winner;
                  burst_cnt <= '0;
                  state     <= GRANT;
               end
            end
            GRANT: begin
               if (bus.req[owner_q]) begin
                  burst_cnt <= burst_cnt + 4'd1;
                  if (burst_cnt == 4'(MAX_BURST - 1)) begin
                     state  <= IDLE;
                     ptr    <= next_ptr;
                     bubble <= 1'b1;
                  end
               end else begin
                  state  <= IDLE;
                  ptr    <= next_ptr;
                  bubble <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: two instances (burst 4 and burst 1) share stimulus and
// are compared every cycle against a behavioural ownership model.
module tb_reg_write_arbiter;
   localparam int W = 8;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   reg_write_arbiter_if #(.WIDTH(W), .N_REQ(N)) ifa ();
   reg_write_arbiter_if #(.WIDTH(W), .N_REQ(N)) ifb ();

   reg_write_arbiter #(.WIDTH(W), .N_REQ(N), .MAX_BURST(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   reg_write_arbiter #(.WIDTH(W), .N_REQ(N), .MAX_BURST(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

   // Shared registers fed by the arbiters.
   logic [W-1:0] reg_a, reg_b;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) reg_a <= '0;
      else if (ifa.load) reg_a <= ifa.data_in;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) reg_b <= '0;
      else if (ifb.load) reg_b <= ifb.data_in;
   end

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Behavioural model: who owns the register, how many writes it has made, and
   // whether the arbiter is still in its post-ownership bubble.
   logic [N-1:0]   cur_req;
   logic [N*W-1:0] cur_data;
   int   m_ptr[2], m_own[2], m_cnt[2];
   bit   m_act[2], m_cool[2];
   logic [W-1:0] m_reg[2];

   function automatic int max_burst(input int u);
      return (u == 0) ? 4 : 1;
   endfunction

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         m_ptr[u] = 0; m_own[u] = 0; m_cnt[u] = 0;
         m_act[u] = 0; m_cool[u] = 0; m_reg[u] = '0;
      end
   endtask

   task automatic release_owner(input int u);
      m_act[u]  = 0;
      m_cool[u] = 1;
      m_ptr[u]  = (m_own[u] + 1) % N;
   endtask

   task automatic model_update();
      for (int u = 0; u < 2; u++) begin
         if (m_act[u]) begin
            if (cur_req[m_own[u]]) begin
               m_reg[u] = cur_data[m_own[u]*W +: W];
               m_cnt[u]++;
               if (m_cnt[u] == max_burst(u)) release_owner(u);
            end else begin
               release_owner(u);
            end
         end else if (m_cool[u]) begin
            m_cool[u] = 0;
         end else if (cur_req != '0) begin
            for (int k = 0; k < N; k++) begin
               if (cur_req[(m_ptr[u] + k) % N]) begin
                  m_own[u] = (m_ptr[u] + k) % N;
                  break;
               end
            end
            m_act[u] = 1;
            m_cnt[u] = 0;
         end
      end
   endtask

   // Observation logs used by the hand-written sequences.
   int           wr_cnt_a[N];
   int           seq_a[$];
   logic [W-1:0] bend_a[$];
   logic [W-1:0] wr_b[$];
   logic         prev_load_a, prev_busy_a;

   task automatic drive(input logic [N-1:0] r, input logic [N*W-1:0] d);
      cur_req = r; cur_data = d;
      ifa.req = r; ifa.req_data = d;
      ifb.req = r; ifb.req_data = d;
   endtask

   task automatic compare_all();
      logic [N-1:0] a_gnt, e_gnt;
      logic         a_load, a_busy, e_wr;
      logic [W-1:0] a_data, e_data, a_reg;
      logic [2:0]   a_owner;
      for (int u = 0; u < 2; u++) begin
         if (u == 0) begin
            a_gnt = ifa.gnt; a_load = ifa.load; a_data = ifa.data_in;
            a_busy = ifa.busy; a_owner = ifa.owner; a_reg = reg_a;
         end else begin
            a_gnt = ifb.gnt; a_load = ifb.load; a_data = ifb.data_in;
            a_busy = ifb.busy; a_owner = ifb.owner; a_reg = reg_b;
         end
         e_wr   = m_act[u] && cur_req[m_own[u]];
         e_gnt  = e_wr ? N'(1 << m_own[u]) : '0;
         e_data = e_wr ? cur_data[m_own[u]*W +: W] : '0;
         check($sformatf("u%0d gnt", u), 32'(a_gnt), 32'(e_gnt));
         check($sformatf("u%0d load", u), 32'(a_load), 32'(e_wr));
         check($sformatf("u%0d data_in", u), 32'(a_data), 32'(e_data));
         check($sformatf("u%0d busy", u), 32'(a_busy), 32'(m_act[u]));
         check($sformatf("u%0d owner", u), 32'(a_owner), 32'(m_own[u]));
         check($sformatf("u%0d register", u), 32'(a_reg), 32'(m_reg[u]));
         check($sformatf("u%0d gnt onehot", u), 32'($countones(a_gnt) <= 1), 32'd1);
         if (u == 0) begin
            if (a_load) begin
               wr_cnt_a[a_owner]++;
               if (!prev_load_a) seq_a.push_back(int'(a_owner));
            end
            if (prev_busy_a && !a_busy) bend_a.push_back(a_reg);
            prev_load_a = a_load;
            prev_busy_a = a_busy;
         end else if (a_load) begin
            wr_b.push_back(a_data);
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic run_cycle();
      @(negedge clk);
      compare_all();
      advance();
   endtask

   task automatic clear_logs();
      for (int i = 0; i < N; i++) wr_cnt_a[i] = 0;
      seq_a.delete(); bend_a.delete(); wr_b.delete();
   endtask

   // Asserts reset away from the clock edge, checks outputs drop at once, then releases.
   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      #1;
      check("rst gnt a", 32'(ifa.gnt), 32'd0);
      check("rst load a", 32'(ifa.load), 32'd0);
      check("rst data_in a", 32'(ifa.data_in), 32'd0);
      check("rst busy a", 32'(ifa.busy), 32'd0);
      check("rst owner a", 32'(ifa.owner), 32'd0);
      check("rst gnt b", 32'(ifb.gnt), 32'd0);
      check("rst busy b", 32'(ifb.busy), 32'd0);
      check("rst register a", 32'(reg_a), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      prev_load_a = 1'b0;
      prev_busy_a = 1'b0;
   endtask

   typedef struct {
      logic [N-1:0] req;
      logic [N-1:0] gnt;
      logic         busy;
      logic [2:0]   owner;
      logic [W-1:0] regv;
   } vec_t;

   vec_t tbl[10];

   initial begin
      logic [W-1:0] exp_bend[5];
      int           exp_seq[5];
      logic [W-1:0] exp6[3];
      logic [N-1:0] rr;

      tbl[0] = '{4'b0100, 4'b0000, 1'b0, 3'd0, 8'h00};
      tbl[1] = '{4'b0100, 4'b0100, 1'b1, 3'd2, 8'h00};
      tbl[2] = '{4'b0100, 4'b0100, 1'b1, 3'd2, 8'h55};
      tbl[3] = '{4'b0100, 4'b0100, 1'b1, 3'd2, 8'h55};
      tbl[4] = '{4'b0100, 4'b0100, 1'b1, 3'd2, 8'h55};
      tbl[5] = '{4'b0100, 4'b0000, 1'b0, 3'd2, 8'h55};
      tbl[6] = '{4'b0100, 4'b0000, 1'b0, 3'd2, 8'h55};
      tbl[7] = '{4'b0100, 4'b0100, 1'b1, 3'd2, 8'h55};
      tbl[8] = '{4'b0100, 4'b0100, 1'b1, 3'd2, 8'h55};
      tbl[9] = '{4'b0100, 4'b0100, 1'b1, 3'd2, 8'h55};
      exp_bend = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
      exp_seq  = '{0, 1, 2, 3, 0};
      exp6     = '{8'hAA, 8'hFF, 8'hAA};

      drive('0, '0);
      clear_logs();
      do_reset();

      // Single requester 2 holding req: arbitration, 4 writes, bubble, arbitration, re-grant.
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].req, 32'h0055_0000);
         @(negedge clk);
         compare_all();
         check($sformatf("tbl%0d gnt", i), 32'(ifa.gnt), 32'(tbl[i].gnt));
         check($sformatf("tbl%0d load", i), 32'(ifa.load), 32'(|tbl[i].gnt));
         check($sformatf("tbl%0d data_in", i), 32'(ifa.data_in), (tbl[i].gnt != '0) ? 32'h55 : 32'h0);
         check($sformatf("tbl%0d busy", i), 32'(ifa.busy), 32'(tbl[i].busy));
         check($sformatf("tbl%0d owner", i), 32'(ifa.owner), 32'(tbl[i].owner));
         check($sformatf("tbl%0d register", i), 32'(reg_a), 32'(tbl[i].regv));
         advance();
      end

      // Reset in the middle of owner 2's second burst; ptr had moved to 3.
      check("pre-reset gnt", 32'(ifa.gnt), 32'h4);
      do_reset();
      clear_logs();
      drive(4'b1010, 32'h4433_2211);
      run_cycle();
      check("first winner after reset", 32'(ifa.owner), 32'd1);

      // Requester 1 drops after two writes while requester 3 waits.
      run_cycle();
      run_cycle();
      drive(4'b1000, 32'h4433_2211);
      for (int i = 0; i < 3; i++) run_cycle();
      check("req1 write count", 32'(wr_cnt_a[1]), 32'd2);
      check("register after req1", 32'(reg_a), 32'h22);
      check("owner after req1 drop", 32'(ifa.owner), 32'd3);

      // Owner 3 finishes its burst; ptr wraps so requester 0 wins.
      drive(4'b1001, 32'h4433_2211);
      for (int i = 0; i < 6; i++) run_cycle();
      check("req3 write count", 32'(wr_cnt_a[3]), 32'd4);
      check("owner after wrap", 32'(ifa.owner), 32'd0);
      check("busy after wrap", 32'(ifa.busy), 32'd1);

      // All four requesting: five full bursts in round-robin order.
      do_reset();
      clear_logs();
      drive(4'b1111, 32'h4433_2211);
      for (int i = 0; i < 31; i++) run_cycle();
      check("burst count", 32'(seq_a.size()), 32'd5);
      check("burst end count", 32'(bend_a.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("burst%0d owner", i), 32'(seq_a[i]), 32'(exp_seq[i]));
         check($sformatf("burst%0d end register", i), 32'(bend_a[i]), 32'(exp_bend[i]));
      end
      check("writes owner0", 32'(wr_cnt_a[0]), 32'd8);
      check("writes owner1", 32'(wr_cnt_a[1]), 32'd4);
      check("writes owner2", 32'(wr_cnt_a[2]), 32'd4);
      check("writes owner3", 32'(wr_cnt_a[3]), 32'd4);

      // Burst length 1: owners 0 and 1 alternate.
      do_reset();
      clear_logs();
      drive(4'b0011, 32'h0000_FFAA);
      for (int i = 0; i < 8; i++) run_cycle();
      check("burst1 write count", 32'(wr_b.size()), 32'd3);
      for (int i = 0; i < 3; i++)
         check($sformatf("burst1 write%0d", i), 32'(wr_b[i]), 32'(exp6[i]));

      // Randomized requests, often held so bursts run to completion.
      do_reset();
      rr = '0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) < 35) rr = N'($urandom_range(0, 15));
         drive(rr, $urandom);
         run_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
